// File: rtl/decodificador_pkg.sv
// decodificador_pkg: shared mode encodings and reference one-hot helper for the decoder slice
package decodificador_pkg;
  localparam logic MODO_NIVEL = 1'b0;
  localparam logic MODO_PULSO = 1'b1;
  function automatic logic [63:0] onehot(input logic [5:0] idx, input int n);
    return (int'(idx) < n) ? (64'd1 << idx) : 64'd0;
  endfunction
endpackage

// File: rtl/decodificador_nucleo.sv
// decodificador_nucleo: combinational ANCHO-to-SALIDAS one-hot core with range compare
module decodificador_nucleo #(
  parameter int ANCHO   = 3,
  parameter int SALIDAS = 8
) (
  input  logic [ANCHO-1:0]   a,
  output logic [SALIDAS-1:0] y,
  output logic               fuera_rango
);
  for (genvar i = 0; i < SALIDAS; i++) begin : g_bit
    assign y[i] = a == ANCHO'(i);
  end
  assign fuera_rango = {1'b0, a} >= (ANCHO+1)'(SALIDAS);
endmodule

// File: rtl/decodificador_param.sv
// decodificador_param: registered one-hot decoder with valid/ready handshake,
// selectable level/pulse output, output polarity and sticky out-of-range error
module decodificador_param
  import decodificador_pkg::*;
#(
  parameter int   ANCHO       = 3,
  parameter int   SALIDAS     = 8,
  parameter logic MODO        = MODO_NIVEL,
  parameter bit   ACTIVO_BAJO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANCHO-1:0]   a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SALIDAS-1:0] y,
  output logic               fuera_rango,
  output logic               error_sticky,
  input  logic               clr_error
);
  if (ANCHO < 1 || ANCHO > 6) begin : g_bad_ancho
    $error("decodificador_param: ANCHO must be 1..6");
  end
  if (SALIDAS < 2 || SALIDAS > (1 << ANCHO)) begin : g_bad_salidas
    $error("decodificador_param: SALIDAS must be 2..2**ANCHO");
  end
  logic [SALIDAS-1:0] dec, reg_q, raw;
  logic               fr, acc;
  decodificador_nucleo #(.ANCHO(ANCHO), .SALIDAS(SALIDAS)) u_nucleo (
    .a(a),
    .y(dec),
    .fuera_rango(fr)
  );
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q        <= '0;
      fuera_rango  <= 1'b0;
      out_valid    <= 1'b0;
      error_sticky <= 1'b0;
    end else begin
      if (acc) begin
        reg_q       <= dec;
        fuera_rango <= fr;
      end
      out_valid    <= acc || (out_valid && !out_ready);
      error_sticky <= (acc && fr) || (error_sticky && !clr_error);
    end
  end
  // pulse mode gates the held word so idle cycles decode to nothing
  assign raw = (MODO == MODO_PULSO) ? (reg_q & {SALIDAS{out_valid}}) : reg_q;
  assign y   = raw ^ {SALIDAS{ACTIVO_BAJO}};
endmodule
